// File: rtl/memaccess_ctrl.sv
// Data-memory port sequencer for the MemAccess stage: direct and indirect
// reads/writes with a configurable read latency behind a busy/done handshake.
module memaccess_ctrl #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [15:0] DMem_dout,
    output logic [15:0] DMem_addr,
    output logic [15:0] DMem_din,
    output logic        DMem_rd,
    output logic        DMem_en,
    output logic [15:0] memout,
    output logic        busy,
    output logic        done
);
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IND,
        S_IND_WAIT,
        S_ACC,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] eff_q, eff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] memout_d;
    logic [AW-1:0] dmem_addr_d, dmem_din_d;
    logic          dmem_rd_d, dmem_en_d, busy_d, done_d;
    logic          accept;

    // Next state, latched command fields, and the registered outputs of the next state
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        eff_d    = eff_q;
        cnt_d    = cnt_q;
        memout_d = memout;
        accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IND: begin
                state_d = S_IND_WAIT;
                cnt_d   = CNT_INIT;
            end
            S_IND_WAIT: begin
                if (cnt_q == '0) begin
                    eff_d   = DMem_dout;
                    state_d = S_ACC;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACC: begin
                if (op_q[0]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == '0) begin
                    memout_d = DMem_dout;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_IDLE, S_DONE: state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase

        // A new command may only land while idle or in the completion cycle
        if (accept) begin
            op_d    = op;
            addr_d  = addr;
            wdata_d = wdata;
            eff_d   = addr;
            state_d = op[1] ? S_IND : S_ACC;
        end

        dmem_en_d   = (state_d == S_IND) || (state_d == S_ACC);
        dmem_rd_d   = !((state_d == S_ACC) && op_d[0]);
        dmem_addr_d = '0;
        dmem_din_d  = '0;
        if (state_d == S_IND) begin
            dmem_addr_d = addr_d;
        end else if (state_d == S_ACC) begin
            dmem_addr_d = eff_d;
            if (op_d[0]) begin
                dmem_din_d = wdata_d;
            end
        end
        busy_d = (state_d == S_IND) || (state_d == S_IND_WAIT) ||
                 (state_d == S_ACC) || (state_d == S_RD_WAIT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            eff_q     <= '0;
            cnt_q     <= '0;
            memout    <= '0;
            DMem_addr <= '0;
            DMem_din  <= '0;
            DMem_rd   <= 1'b1;
            DMem_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            eff_q     <= eff_d;
            cnt_q     <= cnt_d;
            memout    <= memout_d;
            DMem_addr <= dmem_addr_d;
            DMem_din  <= dmem_din_d;
            DMem_rd   <= dmem_rd_d;
            DMem_en   <= dmem_en_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
